// File: rtl/pause_dim_ctrl.sv
// pause_dim_ctrl: pause and screen-dim controller for arcade cores.
//
// Merges a user pause toggle with NUM_REQ level pause requests into one registered pause,
// and dims the core's RGB after DIM_TICKS clocks of uninterrupted user pause. Any player
// activity un-dims while keeping the core paused. Each colour channel is shifted within its
// own width so no bits leak between channels.
//
// Optional feature macro: PAUSE_OSD_EN adds osd_status, which forces pause and holds the dim
// timer at zero while the OSD is open.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   pause_btn   user pause button level (rising edge toggles user pause)
//   pause_req   level pause requests, OR-ed together
//   activity    1-cycle strobe on any joystick/button change
//   osd_status  OSD open (only with PAUSE_OSD_EN)
//   rgb_in      core pixel {r,g,b}
//   rgb_out     pixel to video pipeline, 1-cycle latency
//   pause       pause to core, 1-cycle latency
//   user_paused user toggle state
//   dimmed      dim currently applied to rgb_out
module pause_dim_ctrl #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned RW        = 3,
  parameter int unsigned GW        = 3,
  parameter int unsigned BW        = 2,
  parameter int unsigned TIMER_W   = 32,
  parameter int unsigned DIM_TICKS = 240000000,
  parameter int unsigned DIM_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pause_btn,
  input  logic [NUM_REQ-1:0]    pause_req,
  input  logic                  activity,
`ifdef PAUSE_OSD_EN
  input  logic                  osd_status,
`endif
  input  logic [RW+GW+BW-1:0]   rgb_in,
  output logic [RW+GW+BW-1:0]   rgb_out,
  output logic                  pause,
  output logic                  user_paused,
  output logic                  dimmed
);

  localparam logic [TIMER_W-1:0] DimTicks = TIMER_W'(DIM_TICKS);

  typedef enum logic [1:0] {StRun, StPaused, StDimmed} state_e;

  state_e                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  btn_q;
  logic                  pause_q, pause_d;
  logic                  dimmed_q, dimmed_d;
  logic [RW+GW+BW-1:0]   rgb_q, rgb_d;

  logic                  rise;
  logic                  osd_hold;
  logic [TIMER_W:0]      timer_inc;
  logic [RW-1:0]         r_dim;
  logic [GW-1:0]         g_dim;
  logic [BW-1:0]         b_dim;

`ifdef PAUSE_OSD_EN
  assign osd_hold = osd_status;
`else
  assign osd_hold = 1'b0;
`endif

  assign rise = pause_btn & ~btn_q;

  // One extra bit so the saturation compare cannot wrap even when DimTicks is all ones.
  assign timer_inc = {1'b0, timer_q} + {{TIMER_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StRun: begin
        timer_d = '0;
        if (rise) state_d = StPaused;
      end
      StPaused, StDimmed: begin
        if (rise) begin
          // Toggle has priority over activity.
          state_d = StRun;
          timer_d = '0;
        end else if (activity || osd_hold) begin
          state_d = StPaused;
          timer_d = '0;
        end else if (state_q == StDimmed) begin
          timer_d = DimTicks;
        end else if (timer_inc >= {1'b0, DimTicks}) begin
          state_d = StDimmed;
          timer_d = DimTicks;
        end else begin
          timer_d = timer_inc[TIMER_W-1:0];
        end
      end
      default: begin
        state_d = StRun;
        timer_d = '0;
      end
    endcase
  end

  // Each channel shifted inside its own field, zero-filled from the top.
  assign r_dim = rgb_in[RW+GW+BW-1 -: RW] >> DIM_SHIFT;
  assign g_dim = rgb_in[GW+BW-1 -: GW] >> DIM_SHIFT;
  assign b_dim = rgb_in[BW-1:0] >> DIM_SHIFT;

  // Outputs are computed from the next state so dimmed and the dimmed pixel appear together.
  always_comb begin
    dimmed_d = (state_d == StDimmed);
    pause_d  = (state_d != StRun) | (|pause_req) | osd_hold;
    rgb_d    = dimmed_d ? {r_dim, g_dim, b_dim} : rgb_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StRun;
      timer_q  <= '0;
      btn_q    <= 1'b0;
      pause_q  <= 1'b0;
      dimmed_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      btn_q    <= pause_btn;
      pause_q  <= pause_d;
      dimmed_q <= dimmed_d;
      rgb_q    <= rgb_d;
    end
  end

  assign rgb_out     = rgb_q;
  assign pause       = pause_q;
  assign dimmed      = dimmed_q;
  assign user_paused = (state_q != StRun);

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Testbench for pause_dim_ctrl with DIM_TICKS=16 and a 3/3/2 pixel. A behavioural model
// tracks "user paused" and "quiet cycles since the last pause/activity" and derives the
// expected outputs; directed tasks also check fixed values.
module tb_pause_dim_ctrl;

  localparam int DimTicks = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pause_btn = 1'b0;
  logic [3:0] pause_req = 4'b0;
  logic       activity = 1'b0;
  logic       osd_status = 1'b0;
  logic [7:0] rgb_in = 8'h00;
  logic [7:0] rgb_out;
  logic       pause;
  logic       user_paused;
  logic       dimmed;

  int checks = 0;
  int errors = 0;

  pause_dim_ctrl #(
    .NUM_REQ  (4),
    .RW       (3),
    .GW       (3),
    .BW       (2),
    .TIMER_W  (32),
    .DIM_TICKS(DimTicks),
    .DIM_SHIFT(1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pause_btn  (pause_btn),
    .pause_req  (pause_req),
    .activity   (activity),
`ifdef PAUSE_OSD_EN
    .osd_status (osd_status),
`endif
    .rgb_in     (rgb_in),
    .rgb_out    (rgb_out),
    .pause      (pause),
    .user_paused(user_paused),
    .dimmed     (dimmed)
  );

  always #5 clk = ~clk;

  // Halve each channel of a 3/3/2 pixel independently.
  function automatic logic [7:0] dim_px(input logic [7:0] p);
    int r, g, b;
    r = p[7:5] / 2;
    g = p[4:2] / 2;
    b = p[1:0] / 2;
    return 8'(r * 32 + g * 4 + b);
  endfunction

  // Reference model.
  logic       m_up, m_prev, m_pause, m_dim;
  int         m_quiet;
  logic [7:0] m_rgb;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_up    <= 1'b0;
      m_prev  <= 1'b0;
      m_quiet <= 0;
      m_pause <= 1'b0;
      m_dim   <= 1'b0;
      m_rgb   <= 8'h00;
    end else begin
      logic up, osd, dim;
      int   q;
      up = m_up;
      q  = m_quiet;
`ifdef PAUSE_OSD_EN
      osd = osd_status;
`else
      osd = 1'b0;
`endif
      if (pause_btn && !m_prev) begin
        up = !up;
        q  = 0;
      end else if (up) begin
        if (activity || osd) q = 0;
        else if (q < DimTicks) q = q + 1;
      end
      dim = up && (q >= DimTicks);
      m_up    <= up;
      m_quiet <= q;
      m_prev  <= pause_btn;
      m_dim   <= dim;
      m_pause <= up || (|pause_req) || osd;
      m_rgb   <= dim ? dim_px(rgb_in) : rgb_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_btn();
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rgb_in  = 8'hFF;
    #1;
    checks++;
    if ({pause, user_paused, dimmed, rgb_out} !== 11'b0) begin
      errors++;
      $display("FAIL reset_state got p=%b u=%b d=%b rgb=%h want all 0",
               pause, user_paused, dimmed, rgb_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (rgb_out !== 8'hFF || pause !== 1'b0 || dimmed !== 1'b0) begin
      errors++;
      $display("FAIL reset_passthru got rgb=%h p=%b d=%b want rgb=ff p=0 d=0",
               rgb_out, pause, dimmed);
    end
  endtask

  task automatic test_dim();
    int n;
    rgb_in = 8'hFF;
    pulse_btn();
    checks++;
    if (pause !== 1'b1 || user_paused !== 1'b1 || dimmed !== 1'b0) begin
      errors++;
      $display("FAIL dim_enter_pause got p=%b u=%b d=%b want 1 1 0", pause, user_paused, dimmed);
    end
    n = 0;
    while (!dimmed && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== DimTicks) begin
      errors++;
      $display("FAIL dim_latency got %0d clks want %0d", n, DimTicks);
    end
    checks++;
    if (rgb_out !== 8'b011_011_01) begin
      errors++;
      $display("FAIL dim_pixel got %b want 01101101", rgb_out);
    end
  endtask

  task automatic test_activity();
    int n;
    activity = 1'b1;
    tick();
    activity = 1'b0;
    checks++;
    if (dimmed !== 1'b0 || pause !== 1'b1 || user_paused !== 1'b1 || rgb_out !== 8'hFF) begin
      errors++;
      $display("FAIL activity_undim got d=%b p=%b u=%b rgb=%h want 0 1 1 ff",
               dimmed, pause, user_paused, rgb_out);
    end
    n = 0;
    while (!dimmed && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== DimTicks) begin
      errors++;
      $display("FAIL activity_redim got %0d clks want %0d", n, DimTicks);
    end
  endtask

  task automatic test_pause_req();
    pulse_btn();
    checks++;
    if (user_paused !== 1'b0 || pause !== 1'b0 || dimmed !== 1'b0) begin
      errors++;
      $display("FAIL req_to_run got u=%b p=%b d=%b want 0 0 0", user_paused, pause, dimmed);
    end
    pause_req = 4'b0100;
    #1;
    checks++;
    if (pause !== 1'b0) begin
      errors++;
      $display("FAIL req_latency got p=%b want 0", pause);
    end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 4) pause_req = 4'b0;
      checks++;
      if (pause !== 1'b1 || dimmed !== 1'b0 || user_paused !== 1'b0) begin
        errors++;
        $display("FAIL req_hold[%0d] got p=%b d=%b u=%b want 1 0 0", k, pause, dimmed, user_paused);
      end
    end
    tick();
    checks++;
    if (pause !== 1'b0) begin
      errors++;
      $display("FAIL req_release got p=%b want 0", pause);
    end
  endtask

  task automatic test_toggle_activity();
    int n;
    pulse_btn();
    n = 0;
    while (!dimmed && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (dimmed !== 1'b1) begin
      errors++;
      $display("FAIL toggle_setup got d=%b want 1", dimmed);
    end
    pause_btn = 1'b1;
    activity  = 1'b1;
    tick();
    pause_btn = 1'b0;
    activity  = 1'b0;
    checks++;
    if (user_paused !== 1'b0 || dimmed !== 1'b0 || pause !== 1'b0) begin
      errors++;
      $display("FAIL toggle_wins got u=%b d=%b p=%b want 0 0 0", user_paused, dimmed, pause);
    end
    // Reset while paused clears everything asynchronously.
    pulse_btn();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pause, user_paused, dimmed, rgb_out} !== 11'b0) begin
      errors++;
      $display("FAIL midreset got p=%b u=%b d=%b rgb=%h want all 0",
               pause, user_paused, dimmed, rgb_out);
    end
    // A button held through reset release is seen as one rise.
    pause_btn = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (user_paused !== 1'b1) begin
      errors++;
      $display("FAIL held_btn_toggle got u=%b want 1", user_paused);
    end
    tick();
    checks++;
    if (user_paused !== 1'b1) begin
      errors++;
      $display("FAIL held_btn_once got u=%b want 1", user_paused);
    end
    pause_btn = 1'b0;
    tick();
    pulse_btn();
    checks++;
    if (user_paused !== 1'b0) begin
      errors++;
      $display("FAIL held_btn_exit got u=%b want 0", user_paused);
    end
  endtask

`ifdef PAUSE_OSD_EN
  task automatic test_osd();
    int bad;
    osd_status = 1'b1;
    tick();
    checks++;
    if (pause !== 1'b1 || user_paused !== 1'b0) begin
      errors++;
      $display("FAIL osd_pause got p=%b u=%b want 1 0", pause, user_paused);
    end
    osd_status = 1'b0;
    tick();
    pulse_btn();
    osd_status = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (dimmed !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL osd_no_dim got %0d dimmed clks want 0", bad);
    end
    osd_status = 1'b0;
    pulse_btn();
  endtask
`endif

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) pause_btn = ~pause_btn;
      activity  = ($urandom_range(0, 39) == 0);
      pause_req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      rgb_in    = 8'($urandom);
      tick();
      checks++;
      if (pause !== m_pause || user_paused !== m_up || dimmed !== m_dim || rgb_out !== m_rgb) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d] got p=%b u=%b d=%b rgb=%h want p=%b u=%b d=%b rgb=%h",
                   k, pause, user_paused, dimmed, rgb_out, m_pause, m_up, m_dim, m_rgb);
        bad++;
      end
    end
    pause_btn = 1'b0;
    activity  = 1'b0;
    pause_req = 4'b0;
  endtask

  initial begin
    test_reset();
    test_dim();
    test_activity();
    test_pause_req();
    test_toggle_activity();
`ifdef PAUSE_OSD_EN
    test_osd();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
